// File: rtl/big_divider.sv
// Iterative unsigned restoring divider: N_WIDTH-bit dividend / D_WIDTH-bit divisor, one quotient bit per clock.
// Optional macro DIVIDER_DIVZERO_FLAG_EN adds the div_by_zero port and a one-cycle divide-by-zero shortcut.
module big_divider #(
    parameter int N_WIDTH = 16,
    parameter int D_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic [N_WIDTH-1:0] quotient,
    output logic [D_WIDTH-1:0] remainder,
    output logic               busy,
    output logic               done
`ifdef DIVIDER_DIVZERO_FLAG_EN
    ,
    output logic               div_by_zero
`endif
);
    localparam int CNT_W = $clog2(N_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q;
    logic [N_WIDTH-1:0] shreg_q;
    logic [N_WIDTH-1:0] shreg_d;
    logic [D_WIDTH-1:0] d_q;
    logic [D_WIDTH-1:0] r_q;
    logic [D_WIDTH-1:0] r_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_WIDTH-1:0] quot_q;
    logic [D_WIDTH-1:0] rem_q;
    logic               busy_q;
    logic               done_q;
    logic [D_WIDTH:0]   r_shift;
    logic               qbit;
`ifdef DIVIDER_DIVZERO_FLAG_EN
    logic               dz_q;
`endif

    // The partial remainder stays below the divisor, so only D_WIDTH bits need storing;
    // the shifted value gets one extra bit for the compare. Dividend bits leave the
    // shift register MSB while quotient bits enter its LSB.
    always_comb begin
        r_shift = {r_q, shreg_q[N_WIDTH-1]};
        qbit    = (r_shift >= {1'b0, d_q});
        r_d     = qbit ? (r_shift[D_WIDTH-1:0] - d_q) : r_shift[D_WIDTH-1:0];
        shreg_d = {shreg_q[N_WIDTH-2:0], qbit};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_DIVZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shreg_q <= dividend;
                        d_q     <= divisor;
                        r_q     <= '0;
                        cnt_q   <= '0;
`ifdef DIVIDER_DIVZERO_FLAG_EN
                        dz_q    <= (divisor == '0);
                        if (divisor == '0) begin
                            // Skip iteration: publish the natural all-ones result at once.
                            quot_q  <= '1;
                            rem_q   <= dividend[D_WIDTH-1:0];
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    shreg_q <= shreg_d;
                    r_q     <= r_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_WIDTH - 1)) begin
                        quot_q  <= shreg_d;
                        rem_q   <= r_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef DIVIDER_DIVZERO_FLAG_EN
    assign div_by_zero = dz_q;
`endif

endmodule
